nibble_addsub_sequencer: RTL

Sequencer and arbiter that shares one external four-bit full adder between two requesters, performing 4·NIB-bit add or subtract operations one nibble per cycle, least significant nibble first. It sits between two client ports and the four-bit full adder datapath. It arbitrates round-robin, steps the adder through the nibbles with a registered carry, and returns the result on a valid/ready port tagged with the winning requester.

---
 rtl/nibble_addsub_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/nibble_addsub_sequencer.sv
// nibble_addsub_sequencer
// Shares one external 4-bit full adder between two requesters. Each operation
// adds or subtracts two 4*NIB-bit operands, one nibble per cycle, starting
// with the least significant nibble. The carry between nibbles is registered.
// Requesters are served round-robin, and each result is tagged with the id of
// the requester that issued it.
// Optional build macro NIBBLE_ADDSUB_SEQUENCER_FLAGS_EN adds the zero and
// signed-overflow result flags (res_zero_o, res_ovf_o).
module nibble_addsub_sequencer #(
   parameter int NIB = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [1:0]           req_valid_i,
   output logic [1:0]           req_ready_o,
   input  logic [2*4*NIB-1:0]   req_a_i,
   input  logic [2*4*NIB-1:0]   req_b_i,
   input  logic [1:0]           req_sub_i,
   output logic [3:0]           fa_a_o,
   output logic [3:0]           fa_b_o,
   output logic                 fa_cin_o,
   input  logic [3:0]           fa_s_i,
   input  logic                 fa_cout_i,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic [4*NIB-1:0]     res_sum_o,
   output logic                 res_co_o,
   output logic                 res_id_o,
   output logic                 busy_o
`ifdef NIBBLE_ADDSUB_SEQUENCER_FLAGS_EN
   ,
   output logic                 res_zero_o,
   output logic                 res_ovf_o
`endif
);

   localparam int W  = 4 * NIB;
   localparam int IW = $clog2(NIB);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_reg;
   logic            last_reg;      // requester granted most recently
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic            sub_reg;
   logic            id_reg;
   logic [IW-1:0]   idx_reg;       // nibble currently on the adder
   logic            carry_reg;     // carry into the current nibble
   logic [3:0]      sum_nib[NIB];
   logic [3:0]      a_nib[NIB];
   logic [3:0]      b_nib[NIB];
   logic            grant_id;
   logic            last_nib;
`ifdef NIBBLE_ADDSUB_SEQUENCER_FLAGS_EN
   logic            msb_cin_reg;   // carry into the operand MSB, for overflow
`endif

   // Nibble views of the latched operands and of the assembled result
   genvar gi;
   generate
      for (gi = 0; gi < NIB; gi++) begin : g_nib
         assign a_nib[gi]               = a_reg[4*gi +: 4];
         assign b_nib[gi]               = b_reg[4*gi +: 4];
         assign res_sum_o[4*gi +: 4]    = sum_nib[gi];
      end
   endgenerate

   assign last_nib    = (idx_reg == IW'(NIB - 1));
   assign busy_o      = (state_reg != IDLE);
   assign res_valid_o = (state_reg == DONE);
   assign res_id_o    = id_reg;
   // The stored carry is raw adder carry; for subtract it inverts to a borrow
   assign res_co_o    = (state_reg == DONE) & (carry_reg ^ sub_reg);

`ifdef NIBBLE_ADDSUB_SEQUENCER_FLAGS_EN
   assign res_zero_o  = (state_reg == DONE) & (res_sum_o == '0);
   assign res_ovf_o   = (state_reg == DONE) & (msb_cin_reg ^ carry_reg);
`endif

   // Round-robin grant; ready only in IDLE and never while reset is held
   always_comb begin
      grant_id    = 1'b0;
      req_ready_o = 2'b00;
      if (req_valid_i == 2'b11)
         grant_id = ~last_reg;
      else if (req_valid_i[1])
         grant_id = 1'b1;
      if (rst_n_i && (state_reg == IDLE) && (req_valid_i != 2'b00))
         req_ready_o[grant_id] = 1'b1;
   end

   // Drive the current nibble to the adder; quiet outside CALC
   always_comb begin
      fa_a_o   = 4'h0;
      fa_b_o   = 4'h0;
      fa_cin_o = 1'b0;
      if (state_reg == CALC) begin
         fa_a_o   = a_nib[idx_reg];
         fa_b_o   = b_nib[idx_reg] ^ {4{sub_reg}};
         fa_cin_o = carry_reg;
      end
   end

   // Sequencer: accept, step through the nibbles, then hold the result
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg   <= IDLE;
         last_reg    <= 1'b1;
         a_reg       <= '0;
         b_reg       <= '0;
         sub_reg     <= 1'b0;
         id_reg      <= 1'b0;
         idx_reg     <= '0;
         carry_reg   <= 1'b0;
         for (int k = 0; k < NIB; k++)
            sum_nib[k] <= 4'h0;
`ifdef NIBBLE_ADDSUB_SEQUENCER_FLAGS_EN
         msb_cin_reg <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_ready_o != 2'b00) begin
                  last_reg  <= grant_id;
                  id_reg    <= grant_id;
                  a_reg     <= grant_id ? req_a_i[2*W-1:W] : req_a_i[W-1:0];
                  b_reg     <= grant_id ? req_b_i[2*W-1:W] : req_b_i[W-1:0];
                  sub_reg   <= req_sub_i[grant_id];
                  carry_reg <= req_sub_i[grant_id];
                  idx_reg   <= '0;
                  state_reg <= CALC;
               end
            end
            CALC: begin
               sum_nib[idx_reg] <= fa_s_i;
               carry_reg        <= fa_cout_i;
               idx_reg          <= idx_reg + IW'(1);
               if (last_nib) begin
`ifdef NIBBLE_ADDSUB_SEQUENCER_FLAGS_EN
                  // sum bit = a ^ b ^ cin, so cin is recovered from the sum
                  msb_cin_reg <= fa_s_i[3] ^ fa_a_o[3] ^ fa_b_o[3];
`endif
                  state_reg <= DONE;
               end
            end
            DONE: begin
               if (res_ready_i)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
